// File: rtl/dma_xfer_sequencer_if.sv
// dma_xfer_sequencer_if: pin-level bundle between the DMA sequencer, the system bus and the address/count datapath.
// Latency: none, wires only.
// Backpressure: none here; the sequencer paces itself on hlda, dreq and eop_n_in.
interface dma_xfer_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH);

  // Requests and per-channel setup
  logic [NUM_CH-1:0]   dreq;
  logic [NUM_CH-1:0]   ch_mask;
  logic                rot_pri;
  logic                ext_write;
  logic [2*NUM_CH-1:0] xfer_type;
  logic [2*NUM_CH-1:0] xfer_mode;
  logic [NUM_CH-1:0]   autoinit;

  // Count programming
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_count;

  // Bus handshake and datapath hints
  logic                upper_chg;
  logic                hlda;
  logic                eop_n_in;

  // Sequencer outputs
  logic                hrq;
  logic                aen;
  logic                adstb;
  logic [NUM_CH-1:0]   dack;
  logic                ior_n;
  logic                iow_n;
  logic                memr_n;
  logic                memw_n;
  logic                eop_n_out;
  logic                addr_step;
  logic [CH_W-1:0]     act_ch;
  logic [NUM_CH-1:0]   tc_status;

  // Sequencer side
  modport master (
    input  dreq, ch_mask, rot_pri, ext_write, xfer_type, xfer_mode, autoinit,
    input  cfg_we, cfg_ch, cfg_count, upper_chg, hlda, eop_n_in,
    output hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n,
    output eop_n_out, addr_step, act_ch, tc_status
  );

  // Bus / datapath side
  modport slave (
    output dreq, ch_mask, rot_pri, ext_write, xfer_type, xfer_mode, autoinit,
    output cfg_we, cfg_ch, cfg_count, upper_chg, hlda, eop_n_in,
    input  hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n,
    input  eop_n_out, addr_step, act_ch, tc_status
  );
endinterface

// File: rtl/dma_xfer_sequencer.sv
// dma_xfer_sequencer: N-channel 8237-style DMA cycle sequencer (SI,S0..S4) with arbitration and word counters.
// Latency: hrq one cycle after a valid request; each transfer is [S1],S2,S3,S4 (S2,S4 when compressed).
// Backpressure: holds in S0 until hlda; demand bursts pause when dreq drops; eop_n_in aborts to SI.
// Build option: define COMPRESSED_TIMING_EN to remove S3 and assert read and write strobes together in S2.
module dma_xfer_sequencer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input logic                  CLK,
  input logic                  RESET_N,
  dma_xfer_sequencer_if.master bus
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t state;
  state_t nextState;
  state_t burstState;

  logic [CNT_W-1:0]  baseCnt [NUM_CH];
  logic [CNT_W-1:0]  curCnt  [NUM_CH];
  logic [NUM_CH-1:0] tcFlags;

  logic [CH_W-1:0]   actCh;
  logic [CH_W-1:0]   priPtr;
  logic [CH_W-1:0]   winCh;
  logic [CH_W-1:0]   cand;
  logic [NUM_CH-1:0] validReq;
  logic [NUM_CH-1:0] chOneHot;
  logic [1:0]        actType;
  logic [1:0]        actMode;
  logic              isRead;
  logic              isWrite;
  logic              isTc;
  logic              eopIn;
  logic              busNext;
  logic              rdNext;
  logic              wrNext;

  logic              hrqR;
  logic              aenR;
  logic              adstbR;
  logic [NUM_CH-1:0] dackR;
  logic              iorR;
  logic              iowR;
  logic              memrR;
  logic              memwR;
  logic              eopOutR;
  logic              stepR;

  assign validReq   = bus.dreq & ~bus.ch_mask;
  assign actType    = bus.xfer_type[{actCh, 1'b0} +: 2];
  assign actMode    = bus.xfer_mode[{actCh, 1'b0} +: 2];
  // Type 11 is treated as verify: neither direction drives strobes.
  assign isRead     = (actType == 2'b10);
  assign isWrite    = (actType == 2'b01);
  assign isTc       = (curCnt[actCh] == '0);
  assign eopIn      = ~bus.eop_n_in;
  assign chOneHot   = NUM_CH'(1) << actCh;
  // Re-run S1 only when the upper address byte must be re-strobed.
  assign burstState = bus.upper_chg ? S1 : S2;

  // Pick the first unmasked requester, scanning from ch0 (fixed) or from the rotation pointer.
  always_comb begin
    winCh = '0;
    cand  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = bus.rot_pri ? CH_W'((int'(priPtr) + i) % NUM_CH) : CH_W'(i);
      if (validReq[cand]) winCh = cand;
    end
  end

  // Next-state decode for the S0..S4 bus-cycle sequence.
  always_comb begin
    nextState = state;
    case (state)
      SI: if (|validReq) nextState = S0;
      S0: begin
        if (!(|validReq)) nextState = SI;
        else if (bus.hlda) nextState = S1;
      end
      S1: nextState = eopIn ? SI : S2;
`ifdef COMPRESSED_TIMING_EN
      S2: nextState = eopIn ? SI : S4;
`else
      S2: nextState = eopIn ? SI : S3;
`endif
      S3: nextState = eopIn ? SI : S4;
      S4: begin
        if (isTc || eopIn) begin
          nextState = SI;
        end else begin
          case (actMode)
            2'b10:   nextState = burstState;
            2'b00:   nextState = bus.dreq[actCh] ? burstState : SI;
            default: nextState = SI;
          endcase
        end
      end
      default: nextState = SI;
    endcase
  end

  // Strobe windows for the state being entered.
  always_comb begin
    busNext = (nextState inside {S1, S2, S3, S4});
    rdNext  = (nextState inside {S2, S3, S4});
`ifdef COMPRESSED_TIMING_EN
    wrNext  = rdNext;
`else
    wrNext  = (nextState inside {S3, S4}) || ((nextState == S2) && bus.ext_write);
`endif
  end

  // State register plus pin outputs decoded from the next state, so every pin comes straight from a flop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= SI;
      actCh   <= '0;
      priPtr  <= '0;
      hrqR    <= 1'b0;
      aenR    <= 1'b0;
      adstbR  <= 1'b0;
      dackR   <= '0;
      iorR    <= 1'b1;
      iowR    <= 1'b1;
      memrR   <= 1'b1;
      memwR   <= 1'b1;
      eopOutR <= 1'b1;
      stepR   <= 1'b0;
    end else begin
      state <= nextState;
      if (state == SI && nextState == S0) actCh <= winCh;
      // Rotation moves past a channel once its grant ends, however it ended.
      if (bus.rot_pri && (state inside {S1, S2, S3, S4}) && nextState == SI)
        priPtr <= (actCh == CH_W'(NUM_CH - 1)) ? '0 : actCh + 1'b1;
      hrqR    <= (nextState != SI);
      aenR    <= busNext;
      adstbR  <= (nextState == S1);
      dackR   <= busNext ? chOneHot : '0;
      memrR   <= ~(rdNext & isRead);
      iorR    <= ~(rdNext & isWrite);
      iowR    <= ~(wrNext & isRead);
      memwR   <= ~(wrNext & isWrite);
      stepR   <= (nextState == S4);
      eopOutR <= ~((nextState == S4) && isTc);
    end
  end

  // Per-channel base/current counts and sticky TC flags; a config write beats a same-cycle decrement.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        baseCnt[i] <= '0;
        curCnt[i]  <= '0;
      end
      tcFlags <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.cfg_we && bus.cfg_ch == CH_W'(i)) begin
          baseCnt[i] <= bus.cfg_count;
          curCnt[i]  <= bus.cfg_count;
          tcFlags[i] <= 1'b0;
        end else if (state == S4 && actCh == CH_W'(i)) begin
          if (curCnt[i] == '0) begin
            tcFlags[i] <= 1'b1;
            curCnt[i]  <= bus.autoinit[i] ? baseCnt[i] : '1;
          end else begin
            curCnt[i] <= curCnt[i] - 1'b1;
          end
        end
      end
    end
  end

  assign bus.hrq       = hrqR;
  assign bus.aen       = aenR;
  assign bus.adstb     = adstbR;
  assign bus.dack      = dackR;
  assign bus.ior_n     = iorR;
  assign bus.iow_n     = iowR;
  assign bus.memr_n    = memrR;
  assign bus.memw_n    = memwR;
  assign bus.eop_n_out = eopOutR;
  assign bus.addr_step = stepR;
  assign bus.act_ch    = actCh;
  assign bus.tc_status = tcFlags;

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// tb_dma_xfer_sequencer: directed scenarios for the DMA sequencer, cycle-by-cycle pin comparison.
// Latency: n/a.
// Backpressure: n/a.
module tb_dma_xfer_sequencer;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  int   passCnt  = 0;
  int   totalCnt = 0;

  always #5 CLK = ~CLK;

  dma_xfer_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  dma_xfer_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // Pin snapshot: hrq aen adstb dack[3:0] ior iow memr memw eop_out addr_step
  function automatic logic [12:0] obs();
    return {bus.hrq, bus.aen, bus.adstb, bus.dack, bus.ior_n, bus.iow_n,
            bus.memr_n, bus.memw_n, bus.eop_n_out, bus.addr_step};
  endfunction

  // Expected pins for a state code: 0 SI, 1 S0, 2 S1, 3 S2, 4 S3, 5 S4, 6 S4 with terminal count.
  function automatic logic [12:0] expv(input int code, input int ch, input logic [1:0] typ, input bit ext);
    bit tc, inBus, rd, wr;
    int s;
    logic [3:0] dk;
    tc    = (code == 6);
    s     = tc ? 5 : code;
    inBus = (s >= 2);
    rd    = (s >= 3);
    wr    = (s >= 4) || (s == 3 && ext);
    dk    = inBus ? (4'b0001 << ch) : 4'b0000;
    return {s != 0, inBus, s == 2, dk,
            !(rd && typ == 2'b01), !(wr && typ == 2'b10),
            !(rd && typ == 2'b10), !(wr && typ == 2'b01),
            !(s == 5 && tc), s == 5};
  endfunction

  task automatic set_defaults();
    bus.dreq      = '0;
    bus.ch_mask   = '0;
    bus.rot_pri   = 1'b0;
    bus.ext_write = 1'b0;
    bus.xfer_type = '0;
    bus.xfer_mode = '0;
    bus.autoinit  = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_count = '0;
    bus.upper_chg = 1'b0;
    bus.hlda      = 1'b0;
    bus.eop_n_in  = 1'b1;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    set_defaults();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic cfg(input int ch, input logic [CNT_W-1:0] cnt);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_count = cnt;
    @(negedge CLK);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    RESET_N = 1'b0;
    set_defaults();
    repeat (2) @(negedge CLK);
    e = expv(0, 0, 2'b00, 1'b0);
    totalCnt++;
    if (obs() !== e) $display("FAIL reset_pins: got %b want %b", obs(), e); else passCnt++;
    totalCnt++;
    if (bus.tc_status !== 4'b0000) $display("FAIL reset_tc: got %b want 0000", bus.tc_status); else passCnt++;
    totalCnt++;
    if (bus.act_ch !== 2'd0) $display("FAIL reset_actch: got %0d want 0", bus.act_ch); else passCnt++;
    RESET_N = 1'b1;
    @(negedge CLK);
    // Start a block read on ch2 and pull reset in the middle of S3.
    cfg(2, 16'd4);
    bus.xfer_type = 8'b00_10_00_00;
    bus.xfer_mode = 8'b00_10_00_00;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b0100;
    repeat (4) @(negedge CLK);
    e = expv(4, 2, 2'b10, 1'b0);
    totalCnt++;
    if (obs() !== e) $display("FAIL reset_pre_s3: got %b want %b", obs(), e); else passCnt++;
    #2 RESET_N = 1'b0;
    #1;
    e = expv(0, 0, 2'b00, 1'b0);
    totalCnt++;
    if (obs() !== e) $display("FAIL reset_async: got %b want %b", obs(), e); else passCnt++;
    totalCnt++;
    if (bus.act_ch !== 2'd0) $display("FAIL reset_async_actch: got %0d want 0", bus.act_ch); else passCnt++;
  endtask

  task automatic test_single_read();
    int seq [20];
    logic [12:0] e;
    seq = '{1, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 6, 0, 0};
    apply_reset();
    cfg(1, 16'd2);
    bus.xfer_type = 8'b00_00_10_00;
    bus.xfer_mode = 8'b00_00_01_00;
    bus.dreq      = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 1, 2'b10, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL single_read cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 1) bus.hlda = 1'b1;
      if (c == 17) bus.dreq = 4'b0000;
    end
    totalCnt++;
    if (bus.tc_status !== 4'b0010) $display("FAIL single_read_tc: got %b want 0010", bus.tc_status); else passCnt++;
    totalCnt++;
    if (bus.act_ch !== 2'd1) $display("FAIL single_read_actch: got %0d want 1", bus.act_ch); else passCnt++;
  endtask

  task automatic test_block_write();
    int seq [16];
    logic [12:0] e;
    seq = '{1, 2, 3, 4, 5, 3, 4, 5, 3, 4, 5, 3, 4, 6, 0, 0};
    apply_reset();
    cfg(0, 16'd3);
    bus.xfer_type = 8'b00_00_00_01;
    bus.xfer_mode = 8'b00_00_00_10;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 0, 2'b01, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL block_write cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 13) bus.dreq = 4'b0000;
    end
    totalCnt++;
    if (bus.tc_status !== 4'b0001) $display("FAIL block_write_tc: got %b want 0001", bus.tc_status); else passCnt++;
  endtask

  task automatic test_fixed_mask();
    int seq [12];
    logic [12:0] e;
    seq = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    apply_reset();
    cfg(1, 16'd5);
    bus.xfer_mode = 8'b01_01_01_01;
    bus.ch_mask   = 4'b0001;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 1, 2'b00, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL fixed_mask cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 10) bus.dreq = 4'b0000;
    end
  endtask

  task automatic test_rotating();
    int code [6];
    int order [4];
    logic [12:0] e;
    code  = '{1, 2, 3, 4, 5, 0};
    order = '{1, 3, 1, 3};
    apply_reset();
    cfg(1, 16'd5);
    cfg(3, 16'd5);
    bus.rot_pri   = 1'b1;
    bus.xfer_mode = 8'b01_00_01_00;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b1010;
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      e = expv(code[c % 6], order[c / 6], 2'b00, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL rotating cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c % 6 == 1) begin
        totalCnt++;
        if (bus.act_ch !== 2'(order[c / 6]))
          $display("FAIL rotating_actch svc %0d: got %0d want %0d", c / 6, bus.act_ch, order[c / 6]);
        else passCnt++;
      end
      if (c == 22) bus.dreq = 4'b0000;
    end
  endtask

  task automatic test_demand();
    int seq [18];
    logic [12:0] e;
    seq = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 0, 0, 1, 2, 3, 4, 6, 0, 0};
    apply_reset();
    cfg(2, 16'd2);
    bus.xfer_type = 8'b00_01_00_00;
    bus.xfer_mode = 8'b00_00_00_00;
    bus.ext_write = 1'b1;
    bus.upper_chg = 1'b1;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 2, 2'b01, 1'b1);
      totalCnt++;
      if (obs() !== e) $display("FAIL demand cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 7) bus.dreq = 4'b0000;
      if (c == 10) begin
        bus.dreq      = 4'b0100;
        bus.upper_chg = 1'b0;
      end
      if (c == 15) bus.dreq = 4'b0000;
    end
    totalCnt++;
    if (bus.tc_status !== 4'b0100) $display("FAIL demand_tc: got %b want 0100", bus.tc_status); else passCnt++;
  endtask

  task automatic test_eop_autoinit();
    int seq [22];
    logic [12:0] e;
    seq = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 3, 4, 6, 0, 1, 2, 3, 4, 5, 3, 4, 6, 0};
    apply_reset();
    cfg(3, 16'd1);
    bus.xfer_type = 8'b10_00_00_00;
    bus.xfer_mode = 8'b10_00_00_00;
    bus.autoinit  = 4'b1000;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b1000;
    for (int c = 0; c < 22; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 3, 2'b10, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL eop_autoinit cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 2) bus.eop_n_in = 1'b0;
      if (c == 3) begin
        bus.eop_n_in = 1'b1;
        totalCnt++;
        if (bus.tc_status !== 4'b0000) $display("FAIL eop_abort_tc: got %b want 0000", bus.tc_status); else passCnt++;
      end
      if (c == 20) bus.dreq = 4'b0000;
    end
    totalCnt++;
    if (bus.tc_status !== 4'b1000) $display("FAIL autoinit_tc: got %b want 1000", bus.tc_status); else passCnt++;
  endtask

  task automatic test_cfg_collision();
    int seq [12];
    logic [12:0] e;
    seq = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 6, 0};
    apply_reset();
    cfg(0, 16'd5);
    bus.xfer_type = 8'b00_00_00_10;
    bus.xfer_mode = 8'b00_00_00_01;
    bus.hlda      = 1'b1;
    bus.dreq      = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      e = expv(seq[c], 0, 2'b10, 1'b0);
      totalCnt++;
      if (obs() !== e) $display("FAIL cfg_collision cyc %0d: got %b want %b", c, obs(), e); else passCnt++;
      if (c == 4) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'd0;
        bus.cfg_count = 16'd0;
      end
      if (c == 5) bus.cfg_we = 1'b0;
      if (c == 10) bus.dreq = 4'b0000;
    end
    totalCnt++;
    if (bus.tc_status !== 4'b0001) $display("FAIL cfg_collision_tc: got %b want 0001", bus.tc_status); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_block_write();
    test_fixed_mask();
    test_rotating();
    test_demand();
    test_eop_autoinit();
    test_cfg_collision();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
